// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_MEM_LATENCY  = 1;
  localparam int DEF_STARVE_LIMIT = 4;

  // Wide enough for the largest legal MEM_LATENCY (4).
  localparam int LAT_CNT_W = 3;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Read latency counter: loads 1 on a read issue, counts up to MEM_LATENCY, then returns to 0.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tc
);

  localparam logic [LAT_CNT_W-1:0] TERM = LAT_CNT_W'(MEM_LATENCY);

  logic [LAT_CNT_W-1:0] cnt;

  // cnt is 0 whenever no read is outstanding, so tc can only fire in RD_WAIT.
  assign tc = (cnt == TERM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LAT_CNT_W'(1);
    end else if (tc) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt + LAT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Time-shares one single-port memory between a fetch and a data requester,
// data-first with starvation relief for fetch, at most one read outstanding.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_f,
  output logic                  stall_m
);

  localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  state_e          state;
  owner_e          owner;
  logic [SC_W-1:0] starve_cnt;
  logic            lat_tc;
  logic            issue_ok;
  logic            force_if;
  logic            dm_win;
  logic            if_win;
  logic            rd_issue;

  // Gating with rst keeps every combinational output at 0 while in reset.
  assign issue_ok = rst && ((state == IDLE) || lat_tc);
  assign force_if = if_req && (starve_cnt == STARVE_MAX);
  assign dm_win   = dm_req && !force_if;
  assign if_win   = if_req && !dm_win;

  assign if_gnt   = issue_ok && if_win;
  assign dm_gnt   = issue_ok && dm_win;
  assign rd_issue = if_gnt || (dm_gnt && !dm_we);

  assign stall_f  = rst && if_req && !if_gnt;
  assign stall_m  = rst && dm_req && !dm_gnt;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  mem_arb_lat_cnt #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .start(rd_issue),
    .tc   (lat_tc)
  );

  // Read data is captured in the terminal-count cycle; rvalid follows one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= lat_tc && (owner == OWN_IF);
      dm_rvalid <= lat_tc && (owner == OWN_DM);
      if (lat_tc && (owner == OWN_IF)) if_rdata <= mem_rdata;
      if (lat_tc && (owner == OWN_DM)) dm_rdata <= mem_rdata;
      if (rd_issue) begin
        state <= RD_WAIT;
        owner <= dm_gnt ? OWN_DM : OWN_IF;
      end else if (lat_tc) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters (MEM_LATENCY 1 and 3) on shared stimulus, checked every cycle
// against a cycle-arithmetic reference model plus directed scenario checks.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic        if_gnt [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata [2];
  logic        dm_gnt [2];
  logic        dm_rvalid [2];
  logic [31:0] dm_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        stall_f [2];
  logic        stall_m [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .MEM_LATENCY (g == 0 ? 1 : 3),
      .STARVE_LIMIT(STARVE)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_gnt   (dm_gnt[g]),
      .dm_rvalid(dm_rvalid[g]),
      .dm_rdata (dm_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata),
      .stall_f  (stall_f[g]),
      .stall_m  (stall_m[g])
    );
  end

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: per instance, the cycle from which issue is allowed,
  // the pending read (capture cycle and owner) and the expected returns.
  int          next_free [2];
  int          starve [2];
  int          cap_cyc [2];
  bit          pend [2];
  bit          pend_dm [2];
  bit          ev_if [2];
  bit          ev_dm [2];
  bit          last_gi [2];
  logic [31:0] d_if [2];
  logic [31:0] d_dm [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_cycle(input int i);
    logic        issue, frc, dw, iw, gi, gd, rd, cap;
    logic [31:0] ea, ew;
    logic [7:0]  exp_ctl, got_ctl;
    issue = rst && (cyc >= next_free[i]);
    frc   = if_req && (starve[i] == STARVE);
    dw    = dm_req && !frc;
    iw    = if_req && !dw;
    gi    = issue && iw;
    gd    = issue && dw;
    rd    = gi || (gd && !dm_we);
    ea    = gd ? dm_addr : (gi ? if_addr : 32'h0);
    ew    = gd ? dm_wdata : 32'h0;
    exp_ctl = {gi, gd, rst && if_req && !gi, rst && dm_req && !gd,
               gi || gd, gd && dm_we, rst && ev_if[i], rst && ev_dm[i]};
    got_ctl = {if_gnt[i], dm_gnt[i], stall_f[i], stall_m[i],
               mem_en[i], mem_we[i], if_rvalid[i], dm_rvalid[i]};
    check($sformatf("ctl%0d", i), 64'(got_ctl), 64'(exp_ctl));
    check($sformatf("mem_addr%0d", i), 64'(mem_addr[i]), 64'(ea));
    check($sformatf("mem_wdata%0d", i), 64'(mem_wdata[i]), 64'(ew));
    check($sformatf("if_rdata%0d", i), 64'(if_rdata[i]), 64'(rst ? d_if[i] : 32'h0));
    check($sformatf("dm_rdata%0d", i), 64'(dm_rdata[i]), 64'(rst ? d_dm[i] : 32'h0));
    last_gi[i] = gi;
    if (!rst) begin
      next_free[i] = 0;
      starve[i]    = 0;
      pend[i]      = 1'b0;
      ev_if[i]     = 1'b0;
      ev_dm[i]     = 1'b0;
      d_if[i]      = '0;
      d_dm[i]      = '0;
    end else begin
      cap      = pend[i] && (cyc == cap_cyc[i]);
      ev_if[i] = cap && !pend_dm[i];
      ev_dm[i] = cap && pend_dm[i];
      if (ev_if[i]) d_if[i] = mem_rdata;
      if (ev_dm[i]) d_dm[i] = mem_rdata;
      if (cap) pend[i] = 1'b0;
      if (rd) begin
        pend[i]    = 1'b1;
        cap_cyc[i] = cyc + lat_of(i);
        pend_dm[i] = gd;
      end
      if (gi || gd) next_free[i] = cyc + (rd ? lat_of(i) : 1);
      if (gi || !if_req) starve[i] = 0;
      else if (starve[i] < STARVE) starve[i]++;
    end
  endtask

  // Inputs change at the falling edge; outputs are compared just after it.
  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++) model_cycle(i);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    for (int k = 0; k < n; k++) begin
      mem_rdata = $urandom;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      d_if[i] = '0;
      d_dm[i] = '0;
    end
    rst       = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h4;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'hC;
    dm_wdata  = 32'h0;
    mem_rdata = 32'h0;
    @(negedge clk);
    // Requests held through reset must produce no grant or stall.
    tick();
    tick();
    rst = 1'b1;
    #1 check("first_gnt", 64'(dm_gnt[0]), 64'd1);
    tick();
    idle(6);

    // Lone fetch read, L=1: grant at T, rvalid at T+2.
    if_req    = 1'b1;
    if_addr   = 32'h10;
    mem_rdata = 32'hDEADBEEF;
    #1 check("fetch_gnt", 64'(if_gnt[0]), 64'd1);
    check("fetch_addr", 64'(mem_addr[0]), 64'h10);
    tick();
    if_req = 1'b0;
    tick();
    #1 check("fetch_rvalid", 64'(if_rvalid[0]), 64'd1);
    check("fetch_rdata", 64'(if_rdata[0]), 64'hDEADBEEF);
    tick();
    idle(6);

    // Conflict: data wins, fetch stalls, fetch wins the next issue slot.
    if_req  = 1'b1;
    if_addr = 32'h30;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h20;
    #1 check("conf_dm_gnt", 64'(dm_gnt[0]), 64'd1);
    check("conf_stall_f", 64'(stall_f[0]), 64'd1);
    tick();
    dm_req = 1'b0;
    #1 check("conf_if_gnt", 64'(if_gnt[0]), 64'd1);
    tick();
    idle(6);

    // Starvation: fetch forced through on every fifth issue slot.
    if_req  = 1'b1;
    if_addr = 32'h44;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h48;
    for (int k = 0; k < 10; k++) begin
      mem_rdata = $urandom;
      #1 check($sformatf("starve_gnt%0d", k), 64'(if_gnt[0]), 64'(k == 4 || k == 9));
      tick();
    end
    idle(6);

    // Write: single-cycle strobe, no read return, FSM stays idle.
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h8;
    dm_wdata = 32'h5A;
    #1 check("wr_we", 64'(mem_we[0]), 64'd1);
    check("wr_wdata", 64'(mem_wdata[0]), 64'h5A);
    check("wr_addr", 64'(mem_addr[0]), 64'h8);
    tick();
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h50;
    #1 check("wr_we_after", 64'(mem_we[0]), 64'd0);
    check("wr_idle_l3", 64'(if_gnt[1]), 64'd1);
    tick();
    if_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check("wr_no_rvalid", 64'({dm_rvalid[0], dm_rvalid[1]}), 64'd0);
      tick();
    end
    idle(6);

    // L=3 back-to-back fetch: grants 3 apart, rvalid 4 after each grant.
    if_addr = 32'h100;
    for (int k = 0; k < 14; k++) begin
      if_req    = (k < 10);
      mem_rdata = $urandom;
      #1 check($sformatf("b2b_gnt%0d", k), 64'(if_gnt[1]), 64'(k < 10 && k % 3 == 0));
      check($sformatf("b2b_rv%0d", k), 64'(if_rvalid[1]),
            64'(k >= 4 && (k - 4) % 3 == 0));
      tick();
    end
    idle(6);

    // Reset one cycle after a read grant discards the outstanding read.
    if_req  = 1'b1;
    if_addr = 32'h40;
    tick();
    if_req = 1'b0;
    rst    = 1'b0;
    #1 check("rst_out0", 64'({if_gnt[0], if_rvalid[0], mem_en[0], stall_f[0]}), 64'd0);
    check("rst_rdata0", 64'(if_rdata[0]), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check("rst_no_rvalid", 64'({if_rvalid[0], if_rvalid[1]}), 64'd0);
      tick();
    end

    // Random traffic; a request is renewed once granted (by the L=1 unit) or dropped.
    for (int k = 0; k < 400; k++) begin
      if (!if_req || last_gi[0]) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        if_req = 1'b0;
      end
      if (!dm_req || dm_gnt[0] === 1'bx || k % 2 == 0) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = ($urandom_range(0, 2) == 0);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
      mem_rdata = $urandom;
      tick();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MEM_LATENCY, 1, cycles from issue to read data; legal range 1..4
- STARVE_LIMIT, 4, consecutive fetch denials before fetch is forced to win
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid, 1-cycle pulse
- if_rdata  out  DATA_WIDTH  fetch read data
- dm_req  in  1  data-side request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  data read valid, 1-cycle pulse
- dm_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after issue
- stall_f  out  1  if_req && !if_gnt
- stall_m  out  1  dm_req && !dm_gnt

Function
REQ-003 The block SHALL time-share one single-port memory between two requesters, with at most one read outstanding.
REQ-004 The FSM SHALL have two states:
- IDLE: issue allowed.
- RD_WAIT: a read is outstanding. The latency counter runs from 1 to MEM_LATENCY; issue is allowed only in the cycle the counter equals MEM_LATENCY.
REQ-005 In an issue-allowed cycle, the winner SHALL be selected combinationally:
- dm_req wins, unless the starvation count equals STARVE_LIMIT and if_req is high, in which case fetch wins.
- Exactly one of if_gnt and dm_gnt SHALL be asserted, and only when that requester's req is high.
REQ-006 In a grant cycle, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL come from the winner; mem_we SHALL be 0 for fetch. In all other cycles mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-007 A granted read SHALL move the FSM to RD_WAIT with counter = 1.
REQ-008 A granted write SHALL complete in its grant cycle, keep the FSM in IDLE, and produce no rvalid.
REQ-009 Read return timing:
- When the counter equals MEM_LATENCY, the owner's rvalid SHALL pulse one cycle later, i.e. at T+MEM_LATENCY+1 for a grant at T.
- The owner's rdata SHALL be registered from mem_rdata and held until the next rvalid for that requester.
REQ-010 If no issue happens in the final RD_WAIT cycle, the FSM SHALL go to IDLE. If a new read issues in that cycle, it SHALL re-enter RD_WAIT with counter = 1, giving back-to-back throughput of one read per MEM_LATENCY cycles.
REQ-011 Starvation counter:
- Increments, saturating at STARVE_LIMIT, in each cycle with if_req && !if_gnt.
- Clears on if_gnt or when if_req is low.
REQ-012 Requester contract: req, addr, we and wdata are held stable until gnt. A req may drop before gnt with no side effect.
REQ-013 Simultaneous if_req and dm_req during RD_WAIT SHALL both stall (stall_f = stall_m = 1) and SHALL NOT be granted.

Reset
REQ-014 While rst = 0, every output SHALL be 0, FSM = IDLE, latency counter = 0, and starvation counter = 0.
REQ-015 Reset assertion during RD_WAIT SHALL discard the outstanding read; no rvalid SHALL follow reset release.
REQ-016 The first grant SHALL be possible in the first rising edge cycle after rst deasserts.

Structure
REQ-017 Package mem_arb_pkg SHALL hold:
- the state enum {IDLE, RD_WAIT}
- the owner enum {OWN_IF, OWN_DM}
- default parameter constants
REQ-018 One sub-module, mem_arb_lat_cnt (the latency counter with a terminal-count flag), SHALL be used. Everything else stays in mem_arbiter.

Verification
REQ-019 Bench SHALL cover, with MEM_LATENCY = 1 unless stated:
- Fetch read: if_req, if_addr = 0x10 alone, mem_rdata = 0xDEADBEEF. Expect if_gnt at cycle T and if_rvalid at T+2 with if_rdata = 0xDEADBEEF.
- Conflict: if_req and dm_req (read 0x20) together. Expect dm_gnt, stall_f = 1, then if_gnt at the next issue-allowed cycle.
- Starvation: dm_req held high for 10 cycles with if_req also high. Expect if_gnt on the fifth issue-allowed cycle (STARVE_LIMIT = 4).
- Write: dm_we = 1, dm_addr = 0x8, dm_wdata = 0x5A. Expect mem_we = 1 and mem_wdata = 0x5A for one cycle, FSM remains IDLE, no dm_rvalid.
- MEM_LATENCY = 3, back-to-back fetch reads: grants 3 cycles apart; each if_rvalid 4 cycles after its grant.
- rst pulled low one cycle after a read grant: all outputs 0, and no rvalid ever follows.
